// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Load-use / RAW hazard unit that sits beside the ID stage of the 5-stage
// pipeline. Rather than comparing against a single ID/EX slot, it keeps one
// countdown counter per architectural register. The counter holds the number
// of cycles until the in-flight result for that register reaches the ID stage.
// The ID instruction stalls while any source it reads is not yet forwardable.
//
// Parameters
//   REG_ADDR_W  register specifier width (NUM_REGS = 2**REG_ADDR_W, R0 untracked)
//   ALU_LAT     counter value loaded for an ALU producer
//   LOAD_LAT    counter value loaded for a load producer
//   EX_SLACK    cycles a non-branch consumer gains from EX-stage forwarding
//
// Ports
//   clk            pipeline clock
//   rst            synchronous, active-high reset (clears every counter)
//   id_valid       ID holds a valid instruction
//   id_rs, id_rt   source specifiers
//   id_rs_used     instruction reads rs
//   id_rt_used     instruction reads rt
//   id_rd          destination specifier
//   id_regwrite    instruction writes rd
//   id_is_load     instruction is a load (LOAD_LAT result latency)
//   id_is_branch   instruction is a register-reading branch
//   flush          kill the ID instruction
//   ext_stall      whole pipeline frozen; counters hold
//   stall          hold PC and IF/ID, inject a bubble into ID/EX (same cycle)
//   busy_vec       bit r set while counter r is nonzero; bit 0 always clear
//
// Configuration
//   HAZ_BRANCH_ID_EN  when defined, branches resolve in ID and get no EX-stage
//                     forwarding slack (threshold 0). When undefined,
//                     id_is_branch is ignored and every consumer uses EX_SLACK.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    parameter int EX_SLACK   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_ADDR_W-1:0]      id_rs,
    input  logic [REG_ADDR_W-1:0]      id_rt,
    input  logic                       id_rs_used,
    input  logic                       id_rt_used,
    input  logic [REG_ADDR_W-1:0]      id_rd,
    input  logic                       id_regwrite,
    input  logic                       id_is_load,
    input  logic                       id_is_branch,
    input  logic                       flush,
    input  logic                       ext_stall,
    output logic                       stall,
    output logic [2**REG_ADDR_W-1:0]   busy_vec
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int MAX_LAT  = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
    // Keep at least one counter bit so zero-latency configurations stay legal.
    localparam int CNT_W    = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      ALU_CNT  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0]      LOAD_CNT = CNT_W'(LOAD_LAT);
    localparam logic [31:0]           SLACK    = 32'(EX_SLACK);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    // A source hazards when it is read, is not R0, and its pending result is
    // still further away than the consumer's forwarding slack.
    function automatic logic src_hazard(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] addr,
        input logic [CNT_W-1:0]      cnt,
        input logic [31:0]           thr
    );
        logic [31:0] cnt_ext;
        cnt_ext    = 32'(cnt);
        src_hazard = used & (addr != REG_ZERO) & (cnt_ext > thr);
    endfunction

    logic [CNT_W-1:0]    cnt_r      [NUM_REGS];
    logic [CNT_W-1:0]    cnt_nxt_s  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [31:0]         thr_s;
    logic                haz_rs_s;
    logic                haz_rt_s;
    logic                stall_s;
    logic                issue_s;
    logic                write_s;

`ifndef HAZ_BRANCH_ID_EN
    // Branches resolve in EX in this build, so the branch flag has no effect.
    logic unused_branch_s;
    assign unused_branch_s = id_is_branch;
`endif

    // Forwarding threshold for the instruction currently in ID.
    always_comb begin
        thr_s = SLACK;
`ifdef HAZ_BRANCH_ID_EN
        if (id_is_branch) begin
            thr_s = 32'd0;
        end else begin
            thr_s = SLACK;
        end
`endif
    end

    // Hazard detection and issue qualification, all from registered counters.
    always_comb begin
        haz_rs_s = src_hazard(id_rs_used, id_rs, cnt_r[id_rs], thr_s);
        haz_rt_s = src_hazard(id_rt_used, id_rt, cnt_r[id_rt], thr_s);
        stall_s  = id_valid & ~flush & (haz_rs_s | haz_rt_s);
        issue_s  = id_valid & ~stall_s & ~flush & ~ext_stall;
        write_s  = issue_s & id_regwrite & (id_rd != REG_ZERO);
    end

    // Counter next state: freeze on ext_stall, otherwise decay every entry and
    // let a newly issued producer overwrite its destination (youngest wins).
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt_s[r] = cnt_r[r];
        end
        if (ext_stall) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_nxt_s[r] = cnt_r[r];
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cnt_r[r] != CNT_ZERO) begin
                    cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
                end else begin
                    cnt_nxt_s[r] = CNT_ZERO;
                end
            end
            if (write_s) begin
                cnt_nxt_s[id_rd] = id_is_load ? LOAD_CNT : ALU_CNT;
            end else begin
                cnt_nxt_s[id_rd] = cnt_nxt_s[id_rd];
            end
        end
        // R0 is never tracked.
        cnt_nxt_s[0] = CNT_ZERO;
    end

    // Busy flags computed from the next counter values so the output is a flop.
    always_comb begin
        busy_nxt_s = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_nxt_s[r] = (cnt_nxt_s[r] != CNT_ZERO);
        end
    end

    // Scoreboard and busy-vector registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
            busy_r <= busy_nxt_s;
        end
    end

    assign stall    = stall_s;
    assign busy_vec = busy_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NR       = 16;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;
    localparam int EX_SLACK = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [3:0]    id_rs;
    logic [3:0]    id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic [3:0]    id_rd;
    logic          id_regwrite;
    logic          id_is_load;
    logic          id_is_branch;
    logic          flush;
    logic          ext_stall;
    logic          stall;
    logic [NR-1:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    // Model: a clock of non-frozen cycles and, per register, the moment its
    // result becomes available. Remaining latency = ready time - current time.
    int t_act = 0;
    int ready [NR];
    bit model_ok = 1'b0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_is_branch(id_is_branch), .flush(flush), .ext_stall(ext_stall),
        .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rem(input int r);
        int d;
        d = ready[r] - t_act;
        return (d > 0) ? d : 0;
    endfunction

    // Compare process: check outputs against the model, then advance the model.
    always @(negedge clk) begin
        int            thr;
        int            lat;
        logic          es;
        logic [NR-1:0] eb;
        if (rst) begin
            model_ok = 1'b1;
            t_act    = 0;
            for (int r = 0; r < NR; r++) ready[r] = 0;
        end else if (model_ok) begin
            thr = EX_SLACK;
`ifdef HAZ_BRANCH_ID_EN
            if (id_is_branch) thr = 0;
`endif
            es = id_valid && !flush &&
                 ((id_rs_used && id_rs != 4'd0 && rem(int'(id_rs)) > thr) ||
                  (id_rt_used && id_rt != 4'd0 && rem(int'(id_rt)) > thr));
            eb = '0;
            for (int r = 1; r < NR; r++) eb[r] = (rem(r) > 0);
            check("model_stall", {31'd0, stall}, {31'd0, es});
            check("model_busy", {16'd0, busy_vec}, {16'd0, eb});
            if (!ext_stall) begin
                t_act++;
                if (id_valid && !es && !flush && id_regwrite && id_rd != 4'd0) begin
                    lat = id_is_load ? LOAD_LAT : ALU_LAT;
                    ready[id_rd] = t_act + lat;
                end
            end
        end
    end

    task automatic drv(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic rsu, input logic rtu, input logic [3:0] rd,
                       input logic rw, input logic ld, input logic br,
                       input logic fl, input logic ex);
        @(posedge clk); #1;
        rst = 1'b0; id_valid = v; id_rs = rs; id_rt = rt;
        id_rs_used = rsu; id_rt_used = rtu; id_rd = rd; id_regwrite = rw;
        id_is_load = ld; id_is_branch = br; flush = fl; ext_stall = ex;
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; id_valid = 1'b0; id_rs = 4'd0; id_rt = 4'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_rd = 4'd0; id_regwrite = 1'b0;
        id_is_load = 1'b0; id_is_branch = 1'b0; flush = 1'b0; ext_stall = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        drv(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();

        // Load r3, then add r4,r3,r5: exactly one stall cycle.
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_busy", {16'd0, busy_vec}, 32'd0);
        drv(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_use_stall", {31'd0, stall}, 32'd1);
        check("load_use_busy", {16'd0, busy_vec}, 32'h0008);
        drv(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_use_release", {31'd0, stall}, 32'd0);

        // add r3 then sub r6,r3,r3: forwarded, never stalls.
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu_fwd_stall", {31'd0, stall}, 32'd0);
        idle(); idle();

        // Branch on r2 after load and after ALU op.
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("br_load_c1", {31'd0, stall}, 32'd1);
        drv(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef HAZ_BRANCH_ID_EN
        check("br_load_c2", {31'd0, stall}, 32'd1);
`else
        check("br_load_c2", {31'd0, stall}, 32'd0);
`endif
        drv(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("br_load_c3", {31'd0, stall}, 32'd0);
        idle(); idle();
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef HAZ_BRANCH_ID_EN
        check("br_alu_c1", {31'd0, stall}, 32'd1);
`else
        check("br_alu_c1", {31'd0, stall}, 32'd0);
`endif
        drv(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("br_alu_c2", {31'd0, stall}, 32'd0);
        idle(); idle();

        // Load r7, consumer held by ext_stall for 3 cycles, one stall after.
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 4'd7, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            check("ext_hold_stall", {31'd0, stall}, 32'd1);
            check("ext_hold_busy", {16'd0, busy_vec}, 32'h0080);
        end
        drv(1'b1, 4'd7, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ext_release_stall", {31'd0, stall}, 32'd1);
        drv(1'b1, 4'd7, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ext_release_issue", {31'd0, stall}, 32'd0);
        idle(); idle();

        // R0 is never a hazard; flush does not clear the scoreboard.
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("r0_stall", {31'd0, stall}, 32'd0);
        check("r0_busy", {16'd0, busy_vec}, 32'h0000);
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_busy", {16'd0, busy_vec}, 32'h0020);
        idle();
        check("flush_decay1", {16'd0, busy_vec}, 32'h0020);
        idle();
        check("flush_decay0", {16'd0, busy_vec}, 32'h0000);

        // Self dependency: lw r8,(r8) after load r8.
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("self_dep_stall", {31'd0, stall}, 32'd1);
        drv(1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("self_dep_issue", {31'd0, stall}, 32'd0);
        drv(1'b1, 4'd0, 4'd8, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("self_dep_rearm", {31'd0, stall}, 32'd1);
        check("self_dep_busy", {16'd0, busy_vec}, 32'h0100);
        idle(); idle();

        // Reset discards pending load r9.
        drv(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        drv(1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_stall", {31'd0, stall}, 32'd0);
        check("post_rst_busy", {16'd0, busy_vec}, 32'h0000);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                do_reset();
            end else begin
                drv($urandom_range(0, 4) != 0,
                    4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            end
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
